fifo_uart_tx: RTL

Serial transmitter stage directly downstream of `fifo_core`. It drains bytes from the FIFO read port whenever the FIFO is non-empty and transmission is enabled. Each byte goes out as an asynchronous serial frame: start bit, data LSB first, optional even parity, one stop bit. The block is the link between the buffered byte stream and the board-level TX pin.

---
 rtl/fifo_uart_tx.sv | 84 ++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains fifo_core one byte per frame and shifts it out as an async serial frame
module fifo_uart_tx #(
  parameter int WIDTH = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_en,
  input  logic             empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             rd_en,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WIDTH) + 1;
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic par_q, par_d, tx_q, tx_d, rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d, tick;
  always_comb begin
    tick = cnt_q == CW'(CLKS_PER_BIT - 1);
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    par_d = par_q;
    unique case (state_q)
      IDLE: state_d = tx_en && !empty ? POP : IDLE;
      POP: state_d = LOAD;
      LOAD: begin
        shift_d = fifo_data;
        par_d = 1'b0;
        bit_d = '0;
        state_d = START;
      end
      START: state_d = tick ? DATA : START;
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        par_d = par_q ^ shift_q[0];
        bit_d = bit_q + BW'(1);
        state_d = bit_q == BW'(WIDTH - 1) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      end
      PARITY: state_d = tick ? STOP : PARITY;
      STOP: state_d = tick ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
    cnt_d = (tick || state_q inside {IDLE, POP, LOAD}) ? '0 : cnt_q + CW'(1);
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
    rd_en_d = state_d == POP;
    busy_d = state_q != IDLE;
    done_d = state_d == STOP && cnt_d == CW'(CLKS_PER_BIT - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_q <= par_d;
      tx_q <= tx_d;
      rd_en_q <= rd_en_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign tx = tx_q;
  assign rd_en = rd_en_q;
  assign busy = busy_q;
  assign tx_done = done_q;
endmodule
